// File: rtl/pio_clkdiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pio_clkdiv_pkg
//  Description : Shared constants and helpers for the PIO fractional clock-
//                enable bank. Holds the default channel/divisor widths, the
//                fixed-point ONE constant and the effective-divisor decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package pio_clkdiv_pkg;

    localparam int unsigned DEF_NCH    = 4;
    localparam int unsigned DEF_INT_W  = 16;
    localparam int unsigned DEF_FRAC_W = 8;

    // 1.0 in the default 16.8 fixed-point format
    localparam int unsigned ONE = 1 << DEF_FRAC_W;

    // Decode a {int, frac} divisor into its effective value D.
    // An int field of zero stands for 2^int_w, and the fraction is ignored
    // in that case so the largest divisor is an exact power of two.
    // The result is wide enough for any supported width; callers cast it
    // down to their W+1-bit divisor.
    function automatic logic [63:0] eff_div(input logic [31:0] i_int,
                                            input logic [31:0] i_frac,
                                            input int unsigned int_w,
                                            input int unsigned frac_w);
        logic [63:0] w_d;
        if (i_int == 32'd0) begin
            w_d = 64'd1 << (int_w + frac_w);
        end else begin
            w_d = (64'(i_int) << frac_w) | 64'(i_frac);
        end
        return w_d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pio_clkdiv_bank_if.sv
`default_nettype none
// ============================================================================
//  Module      : pio_clkdiv_bank_if
//  Description : Control/status bundle of the PIO clock-enable bank.
//                master : drives divisors, writes, enables and restarts,
//                         observes penable/pclk/pending.
//                slave  : the divider bank itself.
//  Signals     : div[NCH*W]   per-channel {int,frac} divisor slices
//                div_wr[NCH]  shadow-register write strobes
//                en[NCH]      channel advance enables
//                restart[NCH] phase-restart pulses
//                penable[NCH] one-cycle strobe per divided period
//                pclk[NCH]    divided-clock level
//                pending[NCH] shadow divisor waiting to be applied
//  Revision    : 1.0 - initial release
// ============================================================================
interface pio_clkdiv_bank_if #(
    parameter int NCH    = 4,
    parameter int INT_W  = 16,
    parameter int FRAC_W = 8
);
    localparam int W = INT_W + FRAC_W;

    logic [NCH*W-1:0] div;
    logic [NCH-1:0]   div_wr;
    logic [NCH-1:0]   en;
    logic [NCH-1:0]   restart;
    logic [NCH-1:0]   penable;
    logic [NCH-1:0]   pclk;
    logic [NCH-1:0]   pending;

    modport master (
        output div, div_wr, en, restart,
        input  penable, pclk, pending
    );

    modport slave (
        input  div, div_wr, en, restart,
        output penable, pclk, pending
    );

endinterface
`default_nettype wire

// File: rtl/pio_clkdiv_chan.sv
`default_nettype none
// ============================================================================
//  Module      : pio_clkdiv_chan
//  Description : One fractional clock-enable channel. A W+1-bit phase
//                accumulator advances by ONE on every enabled cycle and wraps
//                modulo the effective divisor D, producing a one-cycle
//                penable per wrap and a ~50 % duty pclk level. Divisor writes
//                go to a shadow register and are applied at a wrap, while the
//                channel is disabled, or directly on a restart.
//  Ports       : clk, reset      clock and synchronous active-high reset
//                i_div[W]        {int,frac} divisor
//                i_div_wr        load shadow (or active, with i_restart)
//                i_en            advance enable
//                i_restart       zero the phase
//                o_penable       registered strobe
//                o_pclk          registered divided-clock level
//                o_pending       shadow waiting to be applied
//  Revision    : 1.0 - initial release
// ============================================================================
module pio_clkdiv_chan
    import pio_clkdiv_pkg::*;
#(
    parameter int INT_W  = 16,
    parameter int FRAC_W = 8
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    input  wire logic [INT_W+FRAC_W-1:0]  i_div,
    input  wire logic                     i_div_wr,
    input  wire logic                     i_en,
    input  wire logic                     i_restart,
    output logic                          o_penable,
    output logic                          o_pclk,
    output logic                          o_pending
);

    localparam int W = INT_W + FRAC_W;
    localparam logic [W:0] c_ONE = (W+1)'(1) << FRAC_W;

    logic [W:0] r_acc;
    logic [W:0] r_div;       // active effective divisor
    logic [W:0] r_shadow;    // staged effective divisor
    logic       r_pending;
    logic       r_penable;
    logic       r_pclk;

    logic [W:0] w_div_new;
    logic [W:0] w_sum;
    logic       w_wrap;
    logic [W:0] w_acc_nxt;
    logic       w_pclk_nxt;
    logic       w_apply;

    assign w_div_new = (W+1)'(eff_div(32'(i_div[W-1:FRAC_W]),
                                      32'(i_div[FRAC_W-1:0]),
                                      INT_W, FRAC_W));

    // acc < 2^W and ONE < 2^W, so the sum never overflows W+1 bits.
    assign w_sum      = r_acc + c_ONE;
    assign w_wrap     = (w_sum >= r_div);
    assign w_acc_nxt  = w_wrap ? (w_sum - r_div) : w_sum;
    assign w_pclk_nxt = (w_acc_nxt < (r_div >> 1));

    // The staged divisor takes over either at a period boundary (the wrap
    // itself still uses the old D) or immediately while the channel idles.
    assign w_apply = r_pending && (w_wrap || !i_en);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc     <= '0;
            r_div     <= c_ONE;
            r_shadow  <= c_ONE;
            r_pending <= 1'b0;
            r_penable <= 1'b0;
            r_pclk    <= 1'b0;
        end else if (i_restart) begin
            r_acc     <= '0;
            r_penable <= 1'b0;
            r_pclk    <= 1'b0;
            r_pending <= 1'b0;
            if (i_div_wr) begin
                r_div <= w_div_new;
            end else if (r_pending) begin
                r_div <= r_shadow;
            end
        end else begin
            if (i_en) begin
                r_acc     <= w_acc_nxt;
                r_penable <= w_wrap;
                r_pclk    <= w_pclk_nxt;
            end else begin
                r_penable <= 1'b0;
            end

            if (w_apply) begin
                r_div     <= r_shadow;
                r_pending <= 1'b0;
            end

            // A write on an applying edge re-arms pending for the next wrap.
            if (i_div_wr) begin
                r_shadow  <= w_div_new;
                r_pending <= 1'b1;
            end
        end
    end

    assign o_penable = r_penable;
    assign o_pclk    = r_pclk;
    assign o_pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/pio_clkdiv_bank.sv
`default_nettype none
// ============================================================================
//  Module      : pio_clkdiv_bank
//  Description : Bank of NCH independent fractional clock-enable channels,
//                one per PIO state machine. Only slices the shared buses;
//                all behaviour lives in pio_clkdiv_chan.
//  Ports       : clk    system clock
//                reset  synchronous active-high reset
//                bus    pio_clkdiv_bank_if slave modport
//  Revision    : 1.0 - initial release
// ============================================================================
module pio_clkdiv_bank
    import pio_clkdiv_pkg::*;
#(
    parameter int NCH    = DEF_NCH,
    parameter int INT_W  = DEF_INT_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  wire logic         clk,
    input  wire logic         reset,
    pio_clkdiv_bank_if.slave  bus
);

    localparam int W = INT_W + FRAC_W;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        pio_clkdiv_chan #(
            .INT_W  (INT_W),
            .FRAC_W (FRAC_W)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .i_div     (bus.div[g*W +: W]),
            .i_div_wr  (bus.div_wr[g]),
            .i_en      (bus.en[g]),
            .i_restart (bus.restart[g]),
            .o_penable (bus.penable[g]),
            .o_pclk    (bus.pclk[g]),
            .o_pending (bus.pending[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_pio_clkdiv_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pio_clkdiv_bank
//  Description : Directed self-checking bench for pio_clkdiv_bank with
//                hand-computed expected strobe/level patterns.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pio_clkdiv_bank;

    localparam int NCH    = 4;
    localparam int INT_W  = 16;
    localparam int FRAC_W = 8;
    localparam int W      = INT_W + FRAC_W;

    logic clk;
    logic reset;

    pio_clkdiv_bank_if #(.NCH(NCH), .INT_W(INT_W), .FRAC_W(FRAC_W)) bus ();

    pio_clkdiv_bank #(.NCH(NCH), .INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setdiv(input int ch, input logic [15:0] iv, input logic [7:0] fv);
        bus.div[ch*W +: W] = {iv, fv};
    endtask

    logic [9:0] pat10;
    logic [9:0] pclk10;
    logic [3:0] pat4;
    int cnt, spur, interval, first0, first1, firstc, ncoinc, hi, period;

    initial begin
        n_chk = 0;
        n_fail = 0;
        reset = 1'b1;
        bus.div = '0;
        bus.div_wr = '0;
        bus.en = '0;
        bus.restart = '0;
        tick();
        tick();

        // ---------------- reset state ----------------
        chk("reset_penable", bus.penable, 4'b0000);
        chk("reset_pclk",    bus.pclk,    4'b0000);
        chk("reset_pending", bus.pending, 4'b0000);
        reset = 1'b0;

        // ---------------- default D = 1.0 ----------------
        bus.en = 4'b0001;
        tick();
        chk("d1_first_penable", bus.penable[0], 1'b1);
        chk("d1_first_pclk",    bus.pclk[0],    1'b1);
        cnt = 0;
        hi  = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            cnt += int'(bus.penable[0]);
            hi  += int'(bus.pclk[0]);
        end
        chk("d1_penable_count", cnt, 5);
        chk("d1_pclk_count",    hi,  5);
        bus.en = 4'b0000;
        tick();
        chk("d1_disabled_penable", bus.penable[0], 1'b0);

        // ---------------- fractional D = 2.5 ----------------
        setdiv(0, 16'd2, 8'd128);
        bus.div_wr = 4'b0001;
        tick();
        bus.div_wr = 4'b0000;
        chk("frac_pending_set", bus.pending[0], 1'b1);
        tick();
        chk("frac_pending_applied_idle", bus.pending[0], 1'b0);
        bus.restart = 4'b0001;
        tick();
        bus.restart = 4'b0000;
        bus.en = 4'b0001;
        chk("frac_restart_pclk", bus.pclk[0], 1'b0);
        for (int k = 0; k < 10; k++) begin
            tick();
            pat10[k]  = bus.penable[0];
            pclk10[k] = bus.pclk[0];
        end
        // strobes on enabled edges 3,5,8,10 -> intervals 3,2,3,2
        chk("frac_penable_pattern", pat10, 10'b1010010100);
        chk("frac_pulse_count", $countones(pat10), 4);
        // acc_next: 256,512,128,384,0,256,512,128,384,0 vs half-D 320
        chk("frac_pclk_pattern", pclk10, 10'b1010110101);

        // ---------------- glitch-free update 4.0 -> 2.0 ----------------
        setdiv(0, 16'd4, 8'd0);
        bus.div_wr = 4'b0001;
        bus.restart = 4'b0001;
        tick();
        bus.div_wr = 4'b0000;
        bus.restart = 4'b0000;
        chk("upd_restart_pending", bus.pending[0], 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            pat4[k] = bus.penable[0];
        end
        chk("upd_d4_pattern", pat4, 4'b1000);
        tick();
        tick();
        setdiv(0, 16'd2, 8'd0);
        bus.div_wr = 4'b0001;
        tick();
        bus.div_wr = 4'b0000;
        chk("upd_pending_set", bus.pending[0], 1'b1);
        chk("upd_no_early_strobe", bus.penable[0], 1'b0);
        tick();
        chk("upd_period_end_strobe", bus.penable[0], 1'b1);
        chk("upd_pending_cleared", bus.pending[0], 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            pat4[k] = bus.penable[0];
        end
        chk("upd_d2_pattern", pat4, 4'b1010);

        // ---------------- enable gap ----------------
        setdiv(0, 16'd4, 8'd0);
        bus.div_wr = 4'b0001;
        bus.restart = 4'b0001;
        tick();
        bus.div_wr = 4'b0000;
        bus.restart = 4'b0000;
        spur = 0;
        tick();
        spur += int'(bus.penable[0]);
        tick();
        spur += int'(bus.penable[0]);
        bus.en = 4'b0000;
        for (int k = 0; k < 7; k++) begin
            tick();
            spur += int'(bus.penable[0]);
        end
        chk("gap_pclk_held", bus.pclk[0], 1'b0);
        bus.en = 4'b0001;
        interval = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (bus.penable[0]) begin
                interval = 9 + k;
                break;
            end
        end
        chk("gap_no_spurious", spur, 0);
        chk("gap_interval", interval, 11);

        // ---------------- phase alignment D=3 / D=5 ----------------
        setdiv(0, 16'd3, 8'd0);
        bus.div_wr = 4'b0001;
        bus.restart = 4'b0001;
        bus.en = 4'b0001;
        tick();
        setdiv(1, 16'd5, 8'd0);
        bus.div_wr = 4'b0010;
        bus.restart = 4'b0010;
        bus.en = 4'b0011;
        tick();
        bus.div_wr = 4'b0000;
        bus.restart = 4'b0000;
        tick();
        tick();
        bus.restart = 4'b0011;
        tick();
        bus.restart = 4'b0000;
        chk("align_restart_penable", bus.penable[1:0], 2'b00);
        first0 = 0;
        first1 = 0;
        firstc = 0;
        ncoinc = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (bus.penable[0] && first0 == 0) first0 = k;
            if (bus.penable[1] && first1 == 0) first1 = k;
            if (bus.penable[0] && bus.penable[1]) begin
                ncoinc++;
                if (firstc == 0) firstc = k;
            end
        end
        chk("align_first_ch0", first0, 3);
        chk("align_first_ch1", first1, 5);
        chk("align_first_coincide", firstc, 15);
        chk("align_coincide_count", ncoinc, 2);

        // ---------------- maximum divisor (int = 0) ----------------
        setdiv(2, 16'd0, 8'hAB);
        bus.div_wr = 4'b0100;
        bus.restart = 4'b0100;
        bus.en = 4'b0111;
        tick();
        bus.div_wr = 4'b0000;
        bus.restart = 4'b0000;
        hi = 0;
        period = 0;
        for (int k = 1; k <= 70000; k++) begin
            tick();
            hi += int'(bus.pclk[2]);
            if (bus.penable[2]) begin
                period = k;
                break;
            end
        end
        chk("max_period", period, 65536);
        chk("max_pclk_high", hi, 32768);
        chk("max_pclk_at_wrap", bus.pclk[2], 1'b1);

        // ---------------- reset with pending ----------------
        setdiv(1, 16'd7, 8'd0);
        bus.div_wr = 4'b0010;
        tick();
        bus.div_wr = 4'b0000;
        chk("rst_pending_before", bus.pending[1], 1'b1);
        reset = 1'b1;
        tick();
        chk("rst_penable", bus.penable, 4'b0000);
        chk("rst_pclk",    bus.pclk,    4'b0000);
        chk("rst_pending", bus.pending, 4'b0000);
        reset = 1'b0;
        bus.en = 4'b0010;
        tick();
        chk("rst_d1_penable", bus.penable, 4'b0010);
        chk("rst_d1_pclk",    bus.pclk[1], 1'b1);
        tick();
        chk("rst_d1_penable_again", bus.penable[1], 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
